// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: read-modify-write and load-use stalls, taken-branch flushes,
// plus saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int RMW_LAT  = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              alu_result_0,
    input  logic              id_ex_imm_31,
    input  logic [1:0]        id_ex_jump,
    input  logic              id_ex_branch,
    input  logic              id_ex_memRead,
    input  logic              id_ex_memWrite,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic [1:0]        ex_mem_maskMode,
    input  logic              ex_mem_memWrite,
    input  logic              perf_clr,
    output logic              pcFromTaken,
    output logic              pcStall,
    output logic              IF_ID_stall,
    output logic              IF_ID_flush,
    output logic              ID_EX_stall,
    output logic              ID_EX_flush,
    output logic              EX_MEM_flush,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {IDLE, RMW, LU} state_t;

    // The first stall cycle is spent in IDLE, so the counter covers the remaining LAT-1 cycles.
    localparam int RMW_CNT = (RMW_LAT > 1) ? RMW_LAT - 2 : 0;
    localparam int LU_CNT  = (LOAD_LAT > 1) ? LOAD_LAT - 2 : 0;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;

    logic branch_do, taken, rmw_hit, lu_hit;
    logic unused_jump;

    assign unused_jump = id_ex_jump[1];

    assign branch_do = alu_result_0 ^ id_ex_imm_31;
    assign taken     = id_ex_jump[0] | (id_ex_branch & branch_do);
    // Sub-word stores need a read cycle before the write, which collides with any EX memory access.
    assign rmw_hit   = (id_ex_memRead | id_ex_memWrite) & ex_mem_memWrite & ~ex_mem_maskMode[1];
    assign lu_hit    = id_ex_memRead && (id_ex_rd != '0) &&
                       ((rs1_used && rs1 == id_ex_rd) || (rs2_used && rs2 == id_ex_rd));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pcFromTaken  = 1'b0;
        pcStall      = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_stall  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        case (state)
            IDLE: begin
                if (rmw_hit) begin
                    pcStall      = 1'b1;
                    IF_ID_stall  = 1'b1;
                    ID_EX_stall  = 1'b1;
                    EX_MEM_flush = 1'b1;
                    if (RMW_LAT > 1) begin
                        state_nxt = RMW;
                        cnt_nxt   = RMW_CNT[1:0];
                    end
                end else if (taken) begin
                    pcFromTaken = 1'b1;
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                end else if (lu_hit) begin
                    pcStall     = 1'b1;
                    IF_ID_stall = 1'b1;
                    ID_EX_flush = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_nxt = LU;
                        cnt_nxt   = LU_CNT[1:0];
                    end
                end
            end
            RMW: begin
                pcStall      = 1'b1;
                IF_ID_stall  = 1'b1;
                ID_EX_stall  = 1'b1;
                EX_MEM_flush = 1'b1;
                if (cnt == 2'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 2'd1;
            end
            LU: begin
                pcStall     = 1'b1;
                IF_ID_stall = 1'b1;
                ID_EX_flush = 1'b1;
                if (cnt == 2'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 2'd1;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset || perf_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pcStall && stall_cnt != '1)     stall_cnt <= stall_cnt + CNT_W'(1);
            if (pcFromTaken && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
